// File: rtl/mem_access_stage.sv
// MEM stage of the 64-bit RISC-V core: one load/store per instruction over a req/ack port.
// Optional build macro MEM_MISALIGN_TRAP_EN adds a natural-alignment check and the outMisaligned port.
module mem_access_stage #(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      inValid,
    input  logic [BUS_DATA_WIDTH-1:0] inResult,
    input  logic [BUS_DATA_WIDTH-1:0] inDataReg2,
    input  logic [2:0]                inLoadType,
    input  logic [1:0]                inStoreType,
    input  logic                      inMemRead,
    input  logic                      inMemWrite,
    input  logic                      inMemOrReg,
    input  logic                      inRegWrite,
    input  logic [4:0]                inDestRegister,
    output logic                      outStall,
    output logic                      outMemReq,
    output logic                      outMemWe,
    output logic [BUS_DATA_WIDTH-1:0] outMemAddr,
    output logic [BUS_DATA_WIDTH-1:0] outMemWData,
    output logic [7:0]                outMemByteEn,
    input  logic                      inMemAck,
    input  logic [BUS_DATA_WIDTH-1:0] inMemRData,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                      outMisaligned,
`endif
    output logic                      outValid,
    output logic                      outRegWrite,
    output logic                      outMemOrReg,
    output logic [4:0]                outDestRegister,
    output logic [BUS_DATA_WIDTH-1:0] outLoadData,
    output logic [BUS_DATA_WIDTH-1:0] outAluResult,
    output logic [BUS_DATA_WIDTH-1:0] outResultMem
);

    localparam int W = BUS_DATA_WIDTH;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         state, state_next;
    logic           is_load, mem_op, misaligned, start, trap, done, wb_valid;
    logic [1:0]     size;
    logic [2:0]     offset, base;
    logic [7:0]     size_mask, byte_en;
    logic [W-1:0]   wdata, shifted, load_value;
    logic [2:0]     load_type_q, base_q;

    // Access size is 0..3 (byte..doubleword); a load also asserting memWrite stays a load.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        is_load   = inMemRead;
        mem_op    = inMemRead | inMemWrite;
        size      = is_load ? inLoadType[1:0] : inStoreType;
        offset    = inResult[2:0];
        base      = 3'd0;
        size_mask = 8'hFF;
        case (size)
            2'd0: begin base = offset;                 size_mask = 8'h01; end
            2'd1: begin base = {offset[2:1], 1'b0};    size_mask = 8'h03; end
            2'd2: begin base = {offset[2], 2'b00};     size_mask = 8'h0F; end
            default: begin base = 3'd0;                size_mask = 8'hFF; end
        endcase
        byte_en = size_mask << base;
        wdata   = inDataReg2 << {base, 3'b000};
`ifdef MEM_MISALIGN_TRAP_EN
        case (size)
            2'd1:    misaligned = offset[0];
            2'd2:    misaligned = |offset[1:0];
            2'd3:    misaligned = |offset;
            default: misaligned = 1'b0;
        endcase
`else
        misaligned = 1'b0;
`endif
    end

    always_comb begin
        state_next = state;
        outStall   = 1'b0;
        start      = 1'b0;
        trap       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (inValid && mem_op) begin
                    if (misaligned) begin
                        trap = 1'b1;
                    end else begin
                        outStall   = 1'b1;
                        start      = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                outStall = !inMemAck;
                if (inMemAck) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        wb_valid = ((state == IDLE) && inValid && !start) || done;
    end

    // Returned doubleword is shifted down to the captured lane, then sized and extended.
    always_comb begin
        shifted = inMemRData >> {base_q, 3'b000};
        case (load_type_q)
            3'b000:  load_value = {{(W-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_value = {{(W-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_value = {{(W-32){shifted[31]}}, shifted[31:0]};
            3'b011:  load_value = shifted;
            3'b100:  load_value = {{(W-8){1'b0}}, shifted[7:0]};
            3'b101:  load_value = {{(W-16){1'b0}}, shifted[15:0]};
            3'b110:  load_value = {{(W-32){1'b0}}, shifted[31:0]};
            default: load_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetN) begin
            state           <= IDLE;
            outMemReq       <= 1'b0;
            outMemWe        <= 1'b0;
            outMemAddr      <= '0;
            outMemWData     <= '0;
            outMemByteEn    <= '0;
            load_type_q     <= '0;
            base_q          <= '0;
            outValid        <= 1'b0;
            outRegWrite     <= 1'b0;
            outMemOrReg     <= 1'b0;
            outDestRegister <= '0;
            outLoadData     <= '0;
            outAluResult    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            outMisaligned   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (start) begin
                outMemReq    <= 1'b1;
                outMemWe     <= !is_load;
                outMemAddr   <= {inResult[W-1:3], 3'b000};
                outMemWData  <= wdata;
                outMemByteEn <= byte_en;
                load_type_q  <= inLoadType;
                base_q       <= base;
            end else if (done) begin
                outMemReq <= 1'b0;
            end
            // EX holds its inputs stable while stalled, so they are still valid on the ack edge.
            outValid        <= wb_valid;
            outRegWrite     <= wb_valid && inValid && inRegWrite && !trap;
            outMemOrReg     <= inMemOrReg;
            outDestRegister <= inDestRegister;
            outAluResult    <= inResult;
            outLoadData     <= (done && !outMemWe) ? load_value : '0;
`ifdef MEM_MISALIGN_TRAP_EN
            outMisaligned   <= trap;
`endif
        end
    end

    assign outResultMem = outMemOrReg ? outLoadData : outAluResult;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a scoreboard queue of expected writeback results,
// popped whenever outValid is seen, plus immediate-assertion checks on the memory port.
module tb_mem_access_stage;

    typedef struct {
        logic [4:0]  rd;
        logic        reg_write;
        logic [63:0] result_mem;
        logic [63:0] load_data;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic        inValid, inMemRead, inMemWrite, inMemOrReg, inRegWrite, inMemAck;
    logic [63:0] inResult, inDataReg2, inMemRData;
    logic [2:0]  inLoadType;
    logic [1:0]  inStoreType;
    logic [4:0]  inDestRegister;
    logic        outStall, outMemReq, outMemWe, outValid, outRegWrite, outMemOrReg;
    logic [63:0] outMemAddr, outMemWData, outLoadData, outAluResult, outResultMem;
    logic [7:0]  outMemByteEn;
    logic [4:0]  outDestRegister;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        outMisaligned;
`endif

    int      n_cmp = 0;
    int      n_err = 0;
    wb_exp_t sb[$];

    mem_access_stage #(.BUS_DATA_WIDTH(64)) dut (
        .clk(clk), .resetN(resetN), .inValid(inValid), .inResult(inResult),
        .inDataReg2(inDataReg2), .inLoadType(inLoadType), .inStoreType(inStoreType),
        .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inMemOrReg(inMemOrReg),
        .inRegWrite(inRegWrite), .inDestRegister(inDestRegister), .outStall(outStall),
        .outMemReq(outMemReq), .outMemWe(outMemWe), .outMemAddr(outMemAddr),
        .outMemWData(outMemWData), .outMemByteEn(outMemByteEn), .inMemAck(inMemAck),
        .inMemRData(inMemRData),
`ifdef MEM_MISALIGN_TRAP_EN
        .outMisaligned(outMisaligned),
`endif
        .outValid(outValid), .outRegWrite(outRegWrite), .outMemOrReg(outMemOrReg),
        .outDestRegister(outDestRegister), .outLoadData(outLoadData),
        .outAluResult(outAluResult), .outResultMem(outResultMem)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge, then compare any writeback slot against the scoreboard head.
    task automatic next_cycle();
        wb_exp_t e;
        @(posedge clk);
        #2;
        if (outValid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'(outValid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("wb_rd", 64'(outDestRegister), 64'(e.rd));
                check("wb_reg_write", 64'(outRegWrite), 64'(e.reg_write));
                check("wb_result_mem", outResultMem, e.result_mem);
                check("wb_load_data", outLoadData, e.load_data);
            end
        end
    endtask

    task automatic idle();
        inValid    = 1'b0;
        inMemRead  = 1'b0;
        inMemWrite = 1'b0;
        inRegWrite = 1'b0;
        inMemAck   = 1'b0;
    endtask

    task automatic alu_op(input logic [63:0] result, input logic [4:0] rd);
        wb_exp_t e;
        inValid = 1'b1; inResult = result; inMemRead = 1'b0; inMemWrite = 1'b0;
        inMemOrReg = 1'b0; inRegWrite = 1'b1; inDestRegister = rd; inMemAck = 1'b0;
        e.rd = rd; e.reg_write = 1'b1; e.result_mem = result; e.load_data = 64'd0;
        sb.push_back(e);
        #1 check("alu_stall", 64'(outStall), 64'd0);
        next_cycle();
        check("alu_valid", 64'(outValid), 64'd1);
    endtask

    task automatic mem_op(input string tag, input bit load, input bit both,
                          input logic [2:0] ltype, input logic [1:0] stype,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [63:0] rdata, input int delay,
                          input bit chk_be, input logic [7:0] exp_be,
                          input logic [63:0] exp_wdata, input logic [63:0] exp_load,
                          input logic mor, input logic rw, input logic [4:0] rd);
        wb_exp_t e;
        inValid = 1'b1; inResult = addr; inDataReg2 = sdata; inLoadType = ltype;
        inStoreType = stype; inMemRead = load | both; inMemWrite = !load | both;
        inMemOrReg = mor; inRegWrite = rw; inDestRegister = rd; inMemAck = 1'b0;
        e.rd = rd; e.reg_write = rw;
        e.load_data = load ? exp_load : 64'd0;
        e.result_mem = mor ? e.load_data : addr;
        sb.push_back(e);
        #1 check({tag, "_stall_issue"}, 64'(outStall), 64'd1);
        next_cycle();
        check({tag, "_req"}, 64'(outMemReq), 64'd1);
        check({tag, "_we"}, 64'(outMemWe), load ? 64'd0 : 64'd1);
        check({tag, "_addr"}, outMemAddr, addr & ~64'h7);
        if (chk_be) check({tag, "_byte_en"}, 64'(outMemByteEn), 64'(exp_be));
        if (!load) check({tag, "_wdata"}, outMemWData, exp_wdata);
        for (int i = 0; i < delay; i++) begin
            check({tag, "_stall_wait"}, 64'(outStall), 64'd1);
            next_cycle();
            check({tag, "_req_held"}, 64'(outMemReq), 64'd1);
            check({tag, "_addr_held"}, outMemAddr, addr & ~64'h7);
        end
        inMemAck = 1'b1; inMemRData = rdata;
        #1 check({tag, "_stall_ack"}, 64'(outStall), 64'd0);
        next_cycle();
        inMemAck = 1'b0;
        check({tag, "_valid"}, 64'(outValid), 64'd1);
        check({tag, "_req_drop"}, 64'(outMemReq), 64'd0);
    endtask

    initial begin
        resetN = 1'b0;
        inResult = '0; inDataReg2 = '0; inMemRData = '0; inLoadType = '0;
        inStoreType = '0; inMemOrReg = 1'b0; inDestRegister = '0;
        idle();
        next_cycle();
        next_cycle();
        check("rst_valid", 64'(outValid), 64'd0);
        check("rst_req", 64'(outMemReq), 64'd0);
        check("rst_byte_en", 64'(outMemByteEn), 64'd0);
        check("rst_result_mem", outResultMem, 64'd0);
        check("rst_stall", 64'(outStall), 64'd0);
        resetN = 1'b1;

        // Reset while waiting on an ld, then a stray ack that must be ignored.
        inValid = 1'b1; inResult = 64'h3000; inLoadType = 3'b011; inMemRead = 1'b1;
        inMemWrite = 1'b0; inRegWrite = 1'b1; inDestRegister = 5'd9;
        next_cycle();
        check("rstw_req", 64'(outMemReq), 64'd1);
        resetN = 1'b0;
        idle();
        next_cycle();
        check("rstw_req_cleared", 64'(outMemReq), 64'd0);
        check("rstw_valid", 64'(outValid), 64'd0);
        resetN = 1'b1;
        inMemAck = 1'b1; inMemRData = 64'hDEAD_BEEF;
        #1 check("rstw_stall_stray_ack", 64'(outStall), 64'd0);
        next_cycle();
        inMemAck = 1'b0;
        check("rstw_stray_valid", 64'(outValid), 64'd0);
        check("rstw_stray_req", 64'(outMemReq), 64'd0);

        alu_op(64'h1234, 5'd5);
        idle();
        next_cycle();
        check("idle_valid", 64'(outValid), 64'd0);
        check("idle_reg_write", 64'(outRegWrite), 64'd0);

        mem_op("sb", 0, 0, 3'b000, 2'b00, 64'h1003, 64'hAB, 64'd0, 1,
               1, 8'h08, 64'h0000_0000_AB00_0000, 64'd0, 0, 0, 5'd3);
        mem_op("lb", 1, 0, 3'b000, 2'b00, 64'h2005, 64'd0, 64'h0000_8000_0000_0000, 3,
               1, 8'h20, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1, 1, 5'd7);
        mem_op("lbu", 1, 0, 3'b100, 2'b00, 64'h2005, 64'd0, 64'h0000_8000_0000_0000, 3,
               1, 8'h20, 64'd0, 64'h0000_0000_0000_0080, 1, 1, 5'd7);
        mem_op("lw", 1, 0, 3'b010, 2'b00, 64'h2004, 64'd0, 64'h8765_4321_0000_0000, 1,
               1, 8'hF0, 64'd0, 64'hFFFF_FFFF_8765_4321, 1, 1, 5'd8);
        mem_op("lwu", 1, 0, 3'b110, 2'b00, 64'h2004, 64'd0, 64'h8765_4321_0000_0000, 1,
               1, 8'hF0, 64'd0, 64'h0000_0000_8765_4321, 1, 1, 5'd8);
        // Back-to-back sw then lw, each acked on its first request cycle.
        mem_op("sw", 0, 0, 3'b000, 2'b10, 64'h0010, 64'h1122_3344, 64'd0, 0,
               1, 8'h0F, 64'h0000_0000_1122_3344, 64'd0, 0, 0, 5'd0);
        mem_op("lw_b2b", 1, 0, 3'b010, 2'b00, 64'h0018, 64'd0, 64'h0000_0000_7FFF_FFFF, 0,
               1, 8'h0F, 64'd0, 64'h0000_0000_7FFF_FFFF, 1, 1, 5'd10);
        // Odd-offset sh silently aligns down to the halfword at lane 6.
        mem_op("sh_align", 0, 0, 3'b000, 2'b01, 64'h1007, 64'hBEEF, 64'd0, 1,
               1, 8'hC0, 64'hBEEF_0000_0000_0000, 64'd0, 0, 0, 5'd0);
        // Read and write both set behaves as ld.
        mem_op("ld_both", 1, 1, 3'b011, 2'b11, 64'h3008, 64'd0, 64'h0123_4567_89AB_CDEF, 2,
               1, 8'hFF, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 1, 5'd11);
        mem_op("lt111", 1, 0, 3'b111, 2'b00, 64'h3000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1,
               0, 8'h00, 64'd0, 64'd0, 1, 1, 5'd12);
        alu_op(64'h5555_AAAA_0000_FFFF, 5'd31);
        idle();
        next_cycle();
        check("final_valid", 64'(outValid), 64'd0);
        next_cycle();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
